// File: rtl/uart_transmitter_if.sv
// Byte handshake between the UART control logic (master) and the transmitter (slave).
interface uart_transmitter_if;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;

   modport master (output data_in, output data_in_valid, input data_in_ready);
   modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit path: one 8N1 frame per accepted byte, or 8E1 when UART_TX_PARITY_EN is defined.
// All outputs are registered so the TX line never glitches.
module uart_transmitter #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic                clk,
   input  logic                rst,
   uart_transmitter_if.slave   in_if,
   output logic                serial_out
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CW = $clog2(SYMBOL_EDGE_TIME);
   localparam logic [CW-1:0] LAST_CYCLE = CW'(SYMBOL_EDGE_TIME - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t          state;
   logic [CW-1:0]   cycle_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      data_reg;
   logic            ready_q;

   assign in_if.data_in_ready = ready_q;

   // The next level is always loaded on the edge that ends the current symbol,
   // so each level is held for exactly SYMBOL_EDGE_TIME cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cycle_cnt  <= '0;
         bit_cnt    <= '0;
         data_reg   <= '0;
         serial_out <= 1'b1;
         ready_q    <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_if.data_in_valid && ready_q) begin
                  data_reg   <= in_if.data_in;
                  state      <= START;
                  serial_out <= 1'b0;
                  ready_q    <= 1'b0;
                  cycle_cnt  <= '0;
                  bit_cnt    <= '0;
               end
            end
            START: begin
               if (cycle_cnt == LAST_CYCLE) begin
                  cycle_cnt  <= '0;
                  state      <= DATA;
                  serial_out <= data_reg[0];
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end
            DATA: begin
               if (cycle_cnt == LAST_CYCLE) begin
                  cycle_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     state      <= PARITY;
                     serial_out <= ^data_reg;
`else
                     state      <= STOP;
                     serial_out <= 1'b1;
`endif
                  end else begin
                     bit_cnt    <= bit_cnt + 3'd1;
                     serial_out <= data_reg[bit_cnt + 3'd1];
                  end
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (cycle_cnt == LAST_CYCLE) begin
                  cycle_cnt  <= '0;
                  state      <= STOP;
                  serial_out <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cycle_cnt == LAST_CYCLE) begin
                  cycle_cnt <= '0;
                  state     <= IDLE;
                  ready_q   <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               cycle_cnt  <= '0;
               serial_out <= 1'b1;
               ready_q    <= 1'b1;
            end
         endcase
      end
   end

endmodule
